// File: rtl/fphub_pkg.sv
// Shared FP HUB adder types and constants: format widths, extended-mantissa width and the
// unpacked-operand record produced by fphub_unpack.
package fphub_pkg;

    localparam int unsigned M                   = 23;
    localparam int unsigned E                   = 8;
    localparam int unsigned extra_bits_mantissa = 7;

    function automatic int unsigned ext_width(input int unsigned m, input int unsigned xb);
        return m + xb;
    endfunction

    // Width of the alignment shifter datapath
    localparam int unsigned W = ext_width(M, extra_bits_mantissa);

    localparam logic [E-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic         sign;
        logic [E-1:0] exp;
        logic [W-1:0] ext_man;
        logic         is_zero;
        logic         is_special;
    } operand_t;

endpackage

// File: rtl/fphub_align_prep_if.sv
// Handshake and payload bundle of the FP HUB operand-preparation stage.
// The slave modport is the stage itself; the master modport is its environment.
interface fphub_align_prep_if;
    import fphub_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [E+M:0]   x;
    logic [E+M:0]   y;
    logic           sub;

    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   man_big;
    logic [W-1:0]   man_small;
    logic [E:0]     shift_amount;
    logic [E-1:0]   exp_big;
    logic           sign_big;
    logic           eff_sub;
    logic           swap;
    logic           special;
    logic           zero_small;

    modport slave (
        input  in_valid, x, y, sub, out_ready,
        output in_ready, out_valid, man_big, man_small, shift_amount, exp_big,
               sign_big, eff_sub, swap, special, zero_small
    );

    modport master (
        output in_valid, x, y, sub, out_ready,
        input  in_ready, out_valid, man_big, man_small, shift_amount, exp_big,
               sign_big, eff_sub, swap, special, zero_small
    );

endinterface

// File: rtl/fphub_unpack.sv
// Splits a HUB operand into fields and builds its extended mantissa
// {hidden, man, ILSB=1, zeros}; exponent 0 is an exact zero (no subnormals).
module fphub_unpack
    import fphub_pkg::*;
(
    input  logic [E+M:0] op,
    output operand_t     u
);

    logic [E-1:0] exp;

    assign exp = op[E+M-1:M];

    always_comb begin
        u            = '0;
        u.sign       = op[E+M];
        u.exp        = exp;
        u.is_zero    = (exp == '0);
        u.is_special = (exp == EXP_MAX);
        if (exp != '0) begin
            u.ext_man = {1'b1, op[M-1:0], 1'b1, {(extra_bits_mantissa-2){1'b0}}};
        end
    end

endmodule

// File: rtl/fphub_align_prep.sv
// Two-stage operand preparation ahead of the FP HUB alignment shifter.
// Define FPHUB_ALIGN_SAT_EN to clamp shift_amount to the datapath width W.
module fphub_align_prep
    import fphub_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fphub_align_prep_if.slave  bus
);

    localparam logic [E:0] SHIFT_SAT = (E+1)'(W);

    operand_t   ux, uy;
    operand_t   s1_x_q, s1_y_q;
    logic       s1_valid_q;
    logic       s1_sy_eff_q;
    logic       s1_mx_ge_my_q;
    logic [E:0] s1_d_q;

    logic       s2_can_load;
    logic       in_ready;
    logic       swap_c;
    logic [E:0] dist_c;
    logic [E:0] shift_c;

    fphub_unpack u_unpack_x (.op(bus.x), .u(ux));
    fphub_unpack u_unpack_y (.op(bus.y), .u(uy));

    // No skid buffer: readiness ripples combinationally from out_ready
    assign s2_can_load  = !bus.out_valid || bus.out_ready;
    assign in_ready     = !s1_valid_q || s2_can_load;
    assign bus.in_ready = in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_x_q        <= '0;
            s1_y_q        <= '0;
            s1_sy_eff_q   <= 1'b0;
            s1_mx_ge_my_q <= 1'b0;
            s1_d_q        <= '0;
        end else if (in_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_x_q        <= ux;
                s1_y_q        <= uy;
                s1_sy_eff_q   <= uy.sign ^ bus.sub;
                s1_mx_ge_my_q <= (ux.ext_man >= uy.ext_man);
                s1_d_q        <= {1'b0, ux.exp} - {1'b0, uy.exp};
            end
        end
    end

    // Equal magnitudes keep x as the big operand
    always_comb begin
        swap_c = s1_d_q[E] || ((s1_d_q == '0) && !s1_mx_ge_my_q);
        dist_c = swap_c ? ('0 - s1_d_q) : s1_d_q;
`ifdef FPHUB_ALIGN_SAT_EN
        shift_c = (dist_c > SHIFT_SAT) ? SHIFT_SAT : dist_c;
`else
        shift_c = dist_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.man_big      <= '0;
            bus.man_small    <= '0;
            bus.shift_amount <= '0;
            bus.exp_big      <= '0;
            bus.sign_big     <= 1'b0;
            bus.eff_sub      <= 1'b0;
            bus.swap         <= 1'b0;
            bus.special      <= 1'b0;
            bus.zero_small   <= 1'b0;
        end else if (s2_can_load) begin
            bus.out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                bus.man_big      <= swap_c ? s1_y_q.ext_man : s1_x_q.ext_man;
                bus.man_small    <= swap_c ? s1_x_q.ext_man : s1_y_q.ext_man;
                bus.shift_amount <= shift_c;
                bus.exp_big      <= swap_c ? s1_y_q.exp : s1_x_q.exp;
                bus.sign_big     <= swap_c ? s1_sy_eff_q : s1_x_q.sign;
                bus.eff_sub      <= s1_x_q.sign ^ s1_sy_eff_q;
                bus.swap         <= swap_c;
                bus.special      <= s1_x_q.is_special || s1_y_q.is_special;
                bus.zero_small   <= swap_c ? s1_x_q.is_zero : s1_y_q.is_zero;
            end
        end
    end

    // SHIFT_SAT is only referenced in the saturating build
    logic unused_sat;
    assign unused_sat = ^SHIFT_SAT;

endmodule

// File: tb/tb_fphub_align_prep.sv
// Scoreboard bench for fphub_align_prep: directed operand pairs, back-pressure and mid-flight reset.
module tb_fphub_align_prep;
    import fphub_pkg::*;

    typedef struct packed {
        logic [W-1:0] man_big;
        logic [W-1:0] man_small;
        logic [E:0]   shift_amount;
        logic [E-1:0] exp_big;
        logic         sign_big;
        logic         eff_sub;
        logic         swap;
        logic         special;
        logic         zero_small;
    } res_t;

`ifdef FPHUB_ALIGN_SAT_EN
    localparam int SH253 = 30;
    localparam int SH127 = 30;
    localparam int SH128 = 30;
`else
    localparam int SH253 = 253;
    localparam int SH127 = 127;
    localparam int SH128 = 128;
`endif

    localparam logic [W-1:0] MAN10 = 30'h2000_0020;
    localparam logic [W-1:0] MAN15 = 30'h3000_0020;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    res_t sb_q[$];
    int   id_q[$];

    fphub_align_prep_if bus ();

    fphub_align_prep dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(input logic [W-1:0] mb, input logic [W-1:0] ms, input int sh,
                                input logic [E-1:0] eb, input logic sb, input logic es,
                                input logic sw, input logic sp, input logic zs);
        res_t r;
        r.man_big      = mb;
        r.man_small    = ms;
        r.shift_amount = (E+1)'(sh);
        r.exp_big      = eb;
        r.sign_big     = sb;
        r.eff_sub      = es;
        r.swap         = sw;
        r.special      = sp;
        r.zero_small   = zs;
        return r;
    endfunction

    function automatic res_t sample();
        res_t r;
        r.man_big      = bus.man_big;
        r.man_small    = bus.man_small;
        r.shift_amount = bus.shift_amount;
        r.exp_big      = bus.exp_big;
        r.sign_big     = bus.sign_big;
        r.eff_sub      = bus.eff_sub;
        r.swap         = bus.swap;
        r.special      = bus.special;
        r.zero_small   = bus.zero_small;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Presents one pair from the next falling edge; pushes the expectation on acceptance
    task automatic send(input int id, input logic [31:0] xx, input logic [31:0] yy,
                        input logic s, input res_t e);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = xx;
        bus.y        = yy;
        bus.sub      = s;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout pair%0d: in_ready got 0 want 1", id);
        end else begin
            sb_q.push_back(e);
            id_q.push_back(id);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: pops on every output handshake and checks stability while stalled
    res_t prev;
    logic held = 1'b0;
    always begin
        res_t cur;
        res_t exp_r;
        int   id;
        @(negedge clk);
        #2;
        if (rst) begin
            held = 1'b0;
        end else begin
            cur = sample();
            if (held) begin
                n_cmp++;
                if (cur !== prev) begin
                    n_bad++;
                    $display("FAIL hold_stable: got %h want %h", cur, prev);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got %h want none", cur);
                end else begin
                    exp_r = sb_q.pop_front();
                    id    = id_q.pop_front();
                    if (cur !== exp_r) begin
                        n_bad++;
                        $display("FAIL pair%0d: got %h want %h", id, cur, exp_r);
                    end
                end
            end
            held = bus.out_valid && !bus.out_ready;
            prev = cur;
        end
    end

    res_t e1, e2, e3, e4, e5, e6, e7, e8;

    initial begin
        e1 = mk(MAN10, MAN10, 1,     8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e2 = mk(MAN10, MAN10, 2,     8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        e3 = mk(MAN15, MAN15, 0,     8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e4 = mk(MAN10, MAN10, SH253, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e5 = mk(MAN10, '0,    SH127, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e6 = mk(MAN10, MAN10, SH128, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        e7 = mk(MAN15, MAN10, 0,     8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        e8 = mk(MAN10, MAN15, 1,     8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_man_big", 32'(bus.man_big), 32'd0);
        chk("reset_shift", 32'(bus.shift_amount), 32'd0);

        // Single pair: latency check
        send(1, 32'h3F80_0000, 32'h3F00_0000, 1'b0, e1);
        idle();
        #2;
        chk("latency_cycle1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #2;
        chk("latency_cycle2", 32'(bus.out_valid), 32'd1);
        drain();

        // Back-to-back stream
        send(2, 32'h3F00_0000, 32'hC000_0000, 1'b0, e2);
        send(3, 32'h3FC0_0000, 32'h3FC0_0000, 1'b1, e3);
        send(4, 32'h7F00_0000, 32'h0080_0000, 1'b0, e4);
        send(5, 32'h3F80_0000, 32'h0000_0000, 1'b0, e5);
        send(6, 32'h7F80_0000, 32'h3F80_0000, 1'b0, e6);
        send(7, 32'h3F80_0000, 32'hBFC0_0000, 1'b0, e7);
        send(8, 32'h4040_0000, 32'hC080_0000, 1'b1, e8);
        idle();
        drain();

        // Back-pressure: full pipe stalls input, then drains in order
        @(negedge clk);
        bus.out_ready = 1'b0;
        fork
            begin
                send(11, 32'h3F80_0000, 32'h3F00_0000, 1'b0, e1);
                send(12, 32'h3F00_0000, 32'hC000_0000, 1'b0, e2);
                send(13, 32'h3FC0_0000, 32'h3FC0_0000, 1'b1, e3);
                send(14, 32'h7F00_0000, 32'h0080_0000, 1'b0, e4);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                #3;
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_accepted", 32'(sb_q.size()), 32'd2);
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two pairs in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(21, 32'h3F80_0000, 32'h0000_0000, 1'b0, e5);
        send(22, 32'h7F80_0000, 32'h3F80_0000, 1'b0, e6);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("inflight_before_rst", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        sb_q.delete();
        id_q.delete();
        @(negedge clk);
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        #3;
        chk("rst_no_stale", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
